// File: rtl/serial_audio_clock_master.sv
// Master-mode sclk/lrclk generator and bit sequencer for the serial audio path.
// Configuration is latched at start-up and at each frame wrap so that the
// decoder/serializer only ever see a change on a frame boundary.
module serial_audio_clock_master #(
  parameter int unsigned START_HOLDOFF = 16
) (
  input  logic       clk128,
  input  logic       reset,
  input  logic       enable,
  input  logic       bits_32,
  input  logic       is_i2s,
  input  logic       lrclk_polarity,
  output logic       sclk,
  output logic       lrclk,
  output logic       bit_strobe,
  output logic       frame_start,
  output logic       is_left,
  output logic [4:0] bit_index,
  output logic       busy,
  output logic       cfg_bits_32,
  output logic       cfg_is_i2s,
  output logic       cfg_lrclk_polarity
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLDOFF,
    S_RUN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(START_HOLDOFF - 1);

  state_t     state, state_nxt;
  logic [6:0] phase, phase_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       cfg_bits_32_nxt, cfg_is_i2s_nxt, cfg_pol_nxt;

  logic       sclk_d, lrclk_d, bit_strobe_d, frame_start_d, is_left_d, busy_d;
  logic [4:0] bit_index_d;
  logic [6:0] lead_phase;
  logic [7:0] hold_thresh;

  // State, phase, holdoff counter and latched configuration
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      phase              <= '0;
      hold_cnt           <= '0;
      cfg_bits_32        <= 1'b0;
      cfg_is_i2s         <= 1'b0;
      cfg_lrclk_polarity <= 1'b0;
    end else begin
      state              <= state_nxt;
      phase              <= phase_nxt;
      hold_cnt           <= hold_cnt_nxt;
      cfg_bits_32        <= cfg_bits_32_nxt;
      cfg_is_i2s         <= cfg_is_i2s_nxt;
      cfg_lrclk_polarity <= cfg_pol_nxt;
    end
  end

  // Next-state: holdoff count, phase advance, stop only at end of frame
  always_comb begin
    state_nxt       = state;
    phase_nxt       = phase;
    hold_cnt_nxt    = hold_cnt;
    cfg_bits_32_nxt = cfg_bits_32;
    cfg_is_i2s_nxt  = cfg_is_i2s;
    cfg_pol_nxt     = cfg_lrclk_polarity;
    unique case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (enable) begin
          state_nxt       = S_HOLDOFF;
          hold_cnt_nxt    = '0;
          cfg_bits_32_nxt = bits_32;
          cfg_is_i2s_nxt  = is_i2s;
          cfg_pol_nxt     = lrclk_polarity;
        end
      end
      S_HOLDOFF: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
          phase_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      S_RUN: begin
        if (phase == 7'd127) begin
          phase_nxt = '0;
          if (!enable) begin
            state_nxt = S_IDLE;
          end else begin
            cfg_bits_32_nxt = bits_32;
            cfg_is_i2s_nxt  = is_i2s;
            cfg_pol_nxt     = lrclk_polarity;
          end
        end else begin
          phase_nxt = phase + 7'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from next-state values so registered outputs track phase with no lag
  always_comb begin
    sclk_d        = 1'b0;
    lrclk_d       = ~cfg_pol_nxt;
    bit_strobe_d  = 1'b0;
    frame_start_d = 1'b0;
    is_left_d     = 1'b0;
    bit_index_d   = '0;
    busy_d        = (state_nxt != S_IDLE);
    lead_phase    = phase_nxt + (cfg_bits_32_nxt ? 7'd2 : 7'd4);
    hold_thresh   = cfg_bits_32_nxt ? 8'(START_HOLDOFF - 2) : 8'(START_HOLDOFF - 4);
    if (state_nxt == S_RUN) begin
      sclk_d        = cfg_bits_32_nxt ? phase_nxt[0] : phase_nxt[1];
      bit_index_d   = cfg_bits_32_nxt ? phase_nxt[5:1] : {1'b0, phase_nxt[5:2]};
      bit_strobe_d  = cfg_bits_32_nxt ? ~phase_nxt[0] : (phase_nxt[1:0] == 2'b00);
      frame_start_d = (phase_nxt == 7'd0);
      is_left_d     = ~phase_nxt[6];
      lrclk_d       = (cfg_is_i2s_nxt ? lead_phase[6] : phase_nxt[6]) ^ cfg_pol_nxt;
    end else if (state_nxt == S_HOLDOFF && cfg_is_i2s_nxt && hold_cnt_nxt >= hold_thresh) begin
      // I2S: lrclk moves to the left level one sclk period before the first frame
      lrclk_d = cfg_pol_nxt;
    end
  end

  // Output registers
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      sclk        <= 1'b0;
      lrclk       <= 1'b1;
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      is_left     <= 1'b0;
      bit_index   <= '0;
      busy        <= 1'b0;
    end else begin
      sclk        <= sclk_d;
      lrclk       <= lrclk_d;
      bit_strobe  <= bit_strobe_d;
      frame_start <= frame_start_d;
      is_left     <= is_left_d;
      bit_index   <= bit_index_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_audio_clock_master.sv
// Bench for serial_audio_clock_master: per-frame strobe expectations are queued
// by the stimulus and checked by an independent monitor on every bit_strobe.
module tb_serial_audio_clock_master;

  logic       clk128 = 1'b0;
  logic       reset, enable, bits_32, is_i2s, lrclk_polarity;
  logic       sclk, lrclk, bit_strobe, frame_start, is_left, busy;
  logic [4:0] bit_index;
  logic       cfg_bits_32, cfg_is_i2s, cfg_lrclk_polarity;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       fs;
    logic       left;
    logic [4:0] idx;
    logic       lr;
    logic       sc;
    logic       b32;
    logic       i2s;
    logic       pol;
  } strobe_t;

  strobe_t exp_q[$];

  serial_audio_clock_master #(.START_HOLDOFF(16)) dut (
    .clk128             (clk128),
    .reset              (reset),
    .enable             (enable),
    .bits_32            (bits_32),
    .is_i2s             (is_i2s),
    .lrclk_polarity     (lrclk_polarity),
    .sclk               (sclk),
    .lrclk              (lrclk),
    .bit_strobe         (bit_strobe),
    .frame_start        (frame_start),
    .is_left            (is_left),
    .bit_index          (bit_index),
    .busy               (busy),
    .cfg_bits_32        (cfg_bits_32),
    .cfg_is_i2s         (cfg_is_i2s),
    .cfg_lrclk_polarity (cfg_lrclk_polarity)
  );

  always #5 clk128 = ~clk128;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Expected strobe sequence for one full frame: strobe k sits at p = k*P.
  task automatic push_frame(input logic b32, input logic i2s, input logic pol);
    int n = b32 ? 64 : 32;
    int half = n / 2;
    strobe_t r;
    for (int k = 0; k < n; k++) begin
      r.fs   = (k == 0);
      r.left = (k < half);
      r.idx  = 5'(k % half);
      r.sc   = 1'b0;
      r.lr   = i2s ? (pol ^ (k >= half - 1 && k < n - 1)) : (pol ^ (k >= half));
      r.b32  = b32;
      r.i2s  = i2s;
      r.pol  = pol;
      exp_q.push_back(r);
    end
  endtask

  // Monitor: every strobe the DUT shows is matched against the next queued expectation
  always @(negedge clk128) begin
    if (!reset && bit_strobe) begin
      strobe_t act;
      act = {frame_start, is_left, bit_index, lrclk, sclk, cfg_bits_32, cfg_is_i2s, cfg_lrclk_polarity};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: got %03h want none", act);
      end else begin
        strobe_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL strobe: got %03h want %03h", act, e);
        end
      end
    end
  end

  // Enable with the given config and run through HOLDOFF to the first frame_start
  task automatic start_run(input logic b32, input logic i2s, input logic pol, output int cyc);
    bits_32 = b32;
    is_i2s = i2s;
    lrclk_polarity = pol;
    enable = 1'b1;
    push_frame(b32, i2s, pol);
    cyc = 0;
    do begin
      @(negedge clk128);
      cyc++;
      if (cyc == 1) chk("busy_rise", 32'(busy), 1);
      if (cyc == 12) chk("hold_lrclk_early", 32'(lrclk), 32'(!pol));
      if (cyc == 16) chk("hold_lrclk_late", 32'(lrclk), 32'(i2s ? pol : !pol));
      if (cyc == 16) chk("hold_sclk", 32'(sclk), 0);
    end while (!frame_start && cyc < 300);
    chk("first_frame_start", 32'(frame_start), 1);
  endtask

  task automatic wait_fs(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk128);
      cyc++;
    end while (!frame_start && cyc < 300);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk128);
      cyc++;
    end while (busy && cyc < 300);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    enable = 1'b0;
    bits_32 = 1'b0;
    is_i2s = 1'b0;
    lrclk_polarity = 1'b0;
    repeat (3) @(negedge clk128);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_lrclk", 32'(lrclk), 1);
    chk("rst_strobes", 32'({bit_strobe, frame_start}), 0);
    chk("rst_index", 32'({is_left, bit_index}), 0);
    chk("rst_cfg", 32'({cfg_bits_32, cfg_is_i2s, cfg_lrclk_polarity}), 0);
    reset = 1'b0;
    @(negedge clk128);

    // 16-bit left-justified, pol 0; enable glitch mid-frame must not stop
    start_run(1'b0, 1'b0, 1'b0, cnt);
    chk("holdoff_len", cnt, 17);
    repeat (2) @(negedge clk128);
    chk("sclk16_p2", 32'(sclk), 1);
    repeat (18) @(negedge clk128);
    enable = 1'b0;
    repeat (10) @(negedge clk128);
    enable = 1'b1;
    push_frame(1'b0, 1'b0, 1'b0);
    wait_fs(cnt);
    chk("no_stop_on_glitch", cnt, 98);
    repeat (10) @(negedge clk128);
    enable = 1'b0;
    wait_idle(cnt);
    chk("stop_at_frame_end", cnt, 118);
    chk("idle_sclk", 32'(sclk), 0);
    chk("idle_lrclk", 32'(lrclk), 1);
    chk("queue_empty_1", exp_q.size(), 0);

    // 32-bit, switch to 16-bit mid-frame: only takes effect at the wrap
    start_run(1'b1, 1'b0, 1'b0, cnt);
    chk("holdoff_len_32", cnt, 17);
    repeat (40) @(negedge clk128);
    bits_32 = 1'b0;
    chk("cfg32_held", 32'(cfg_bits_32), 1);
    push_frame(1'b0, 1'b0, 1'b0);
    @(negedge clk128);
    chk("sclk32_p41", 32'(sclk), 1);
    wait_fs(cnt);
    chk("frame_after_toggle", cnt, 87);
    chk("cfg32_switched", 32'(cfg_bits_32), 0);
    @(negedge clk128);
    chk("sclk16_p1", 32'(sclk), 0);
    repeat (9) @(negedge clk128);
    enable = 1'b0;
    wait_idle(cnt);
    chk("stop_32", cnt, 118);
    chk("queue_empty_2", exp_q.size(), 0);

    // I2S 16-bit pol 0, then pol 1 latched at the wrap
    start_run(1'b0, 1'b1, 1'b0, cnt);
    chk("holdoff_len_i2s", cnt, 17);
    repeat (30) @(negedge clk128);
    lrclk_polarity = 1'b1;
    push_frame(1'b0, 1'b1, 1'b1);
    repeat (29) @(negedge clk128);
    chk("i2s_lr_p59", 32'(lrclk), 0);
    @(negedge clk128);
    chk("i2s_lr_p60", 32'(lrclk), 1);
    repeat (63) @(negedge clk128);
    chk("i2s_lr_p123", 32'(lrclk), 1);
    @(negedge clk128);
    chk("i2s_lr_p124", 32'(lrclk), 0);
    wait_fs(cnt);
    chk("i2s_lead", cnt, 4);
    chk("i2s_pol1_p0", 32'(lrclk), 1);
    chk("cfg_pol1", 32'(cfg_lrclk_polarity), 1);
    repeat (10) @(negedge clk128);
    enable = 1'b0;
    wait_idle(cnt);
    chk("stop_i2s", cnt, 118);
    chk("idle_lrclk_pol1", 32'(lrclk), 0);
    chk("queue_empty_3", exp_q.size(), 0);

    // Asynchronous reset mid-frame, then a clean restart
    start_run(1'b1, 1'b0, 1'b0, cnt);
    repeat (70) @(negedge clk128);
    chk("pre_rst_index", 32'(bit_index), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_index", 32'(bit_index), 0);
    chk("arst_cfg32", 32'(cfg_bits_32), 0);
    chk("arst_lrclk", 32'(lrclk), 1);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk128);
    reset = 1'b0;
    @(negedge clk128);
    start_run(1'b0, 1'b0, 1'b0, cnt);
    chk("holdoff_after_rst", cnt, 17);
    repeat (10) @(negedge clk128);
    enable = 1'b0;
    wait_idle(cnt);
    chk("stop_after_rst", cnt, 118);
    chk("queue_empty_4", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
